icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning the byte-address width (1 MB space).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max REFILL cycles before bus error.
REQ-003 SHALL have port CLK_cpu  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports pc_valid  in  1 and pc  in  ADDR_W: the upstream fetch request.
REQ-006 SHALL have port pc_ready  out  1  high when a request is accepted this cycle.
REQ-007 SHALL have ports icache_read_en  out  1 and icache_read_addr  out  ADDR_W: the cache lookup.
REQ-008 SHALL have ports icache_miss  in  1 and icache_instr  in  32: the lookup result, valid in the cycle after the icache_read_en cycle.
REQ-009 SHALL have ports icache_fetch  out  1, icache_write_addr  out  ADDR_W and icache_write_data  out  32: the line fill.
REQ-010 SHALL have ports mem_req  out  1, mem_addr  out  ADDR_W, mem_ack  in  1 and mem_rdata  in  32: the main-memory read.
REQ-011 SHALL have ports instr_valid  out  1, instr  out  32 and instr_addr  out  ADDR_W: delivery downstream.
REQ-012 SHALL have port bus_err  out  1  sticky memory-timeout flag.

Function
REQ-013 SHALL implement the states IDLE, RD, LOOKUP, REFILL, FILL and ERROR.
REQ-014 SHALL register every output (Moore style); no output SHALL depend combinationally on an input.
REQ-015 SHALL hold pc_ready=1 only in IDLE; acceptance = pc_valid && pc_ready; pc_valid outside IDLE SHALL be ignored.
REQ-016 On acceptance, SHALL latch {pc[ADDR_W-1:2],2'b00} into the address register (pc[1:0] ignored) and go to RD.
REQ-017 RD SHALL last one cycle with icache_read_en=1 and icache_read_addr=latched address, then go to LOOKUP.
REQ-018 In LOOKUP with icache_miss=0, SHALL pulse instr_valid for one cycle (instr=icache_instr, instr_addr=latched address) and return to IDLE: hit latency 3 cycles from acceptance edge to instr_valid.
REQ-019 In LOOKUP with icache_miss=1, SHALL go to REFILL and clear the timeout counter.
REQ-020 In REFILL, SHALL hold mem_req=1 and mem_addr=latched address steady until mem_ack; the counter SHALL increment each REFILL cycle without ack.
REQ-021 On mem_ack in REFILL, SHALL capture mem_rdata and go to FILL; an ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win over the timeout.
REQ-022 When the counter reaches TIMEOUT_CYCLES with no ack, SHALL drop mem_req and enter ERROR with bus_err=1.
REQ-023 FILL SHALL last one cycle with icache_fetch=1, icache_write_addr=latched address and icache_write_data=captured word.
REQ-024 In that same FILL cycle, SHALL forward the captured word (instr_valid=1, instr=captured) and then return to IDLE; there is no re-lookup.
REQ-025 SHALL never assert icache_read_en and icache_fetch in the same cycle.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 ERROR SHALL be terminal: pc_ready=0 and bus_err=1 until reset.
REQ-028 instr and instr_addr SHALL hold their last value while instr_valid=0.

Reset
REQ-029 On RST, SHALL enter IDLE with every output 0 (pc_ready becomes 1 the cycle after RST deasserts), the counter at 0 and bus_err at 0.
REQ-030 RST during REFILL or FILL SHALL abandon the operation: mem_req and icache_fetch SHALL be 0 from the next edge, with no instr_valid pulse.

Structure
REQ-031 A shared package icache_pkg SHALL hold ADDR_W, TIMEOUT_CYCLES and the state encoding.
REQ-032 The timeout counter SHALL be a single sub-module refill_timer, with clear, enable and expired signals.

Verification
REQ-033 Hit: pc=0x00104 accepted, icache_miss=0, icache_instr=0x00A00093 -> instr_valid 3 cycles later, instr=0x00A00093, instr_addr=0x00104, and mem_req never asserted.
REQ-034 Miss: pc=0x0FF08, miss=1, mem_ack 5 cycles into REFILL with mem_rdata=0xDEADBEEF -> one icache_fetch pulse (write_addr=0x0FF08, write_data=0xDEADBEEF) coinciding with instr_valid, instr=0xDEADBEEF.
REQ-035 Misaligned pc=0x00107 -> icache_read_addr=0x00104 and instr_addr=0x00104.
REQ-036 Timeout: miss with no mem_ack -> mem_req high for exactly 255 cycles, then bus_err=1 and pc_ready=0 held; a later mem_ack has no effect.
REQ-037 Ack at the limit: mem_ack on REFILL cycle 255 -> FILL taken and bus_err stays 0.
REQ-038 Reset mid-refill at REFILL cycle 3 -> mem_req=0 next cycle, no instr_valid or icache_fetch, pc_ready=1 the cycle after RST deasserts; read_en and fetch never overlap in any scenario.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared constants and state encoding for the instruction-cache
//                refill controller (icache_refill) and its timeout counter
//                (refill_timer).
//  Contents    : ADDR_W          - default byte-address width
//                TIMEOUT_CYCLES  - default REFILL cycles before bus error
//                state_e         - controller state encoding
//                timer_width()   - counter width able to hold a given limit
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int ADDR_W         = 20;
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_FILL   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  // Width needed so the counter can represent the value 'limit' itself.
  function automatic int timer_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/refill_timer.sv
`default_nettype none
// ============================================================================
//  Module      : refill_timer
//  Description : Counts REFILL cycles spent waiting for a memory acknowledge.
//                expired_o is high while the counter sits on its last value
//                before LIMIT, i.e. the current wait cycle is the LIMIT-th one.
//  Ports       : clk_i     - clock (rising edge)
//                rst_i     - synchronous active-high reset
//                clear_i   - load zero (has priority over en_i)
//                en_i      - count one cycle
//                expired_o - current cycle is the final allowed wait cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_timer
  import icache_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = timer_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the register only, so the controller can use it without
  // forming a loop through its own enable logic.
  assign expired_o = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill
//  Description : Instruction-fetch front end. Accepts a fetch address, looks
//                it up in the instruction cache, and on a miss reads the word
//                from main memory, writes it into the cache and forwards it
//                downstream in the same cycle. A memory that never answers
//                parks the block in a terminal bus-error state.
//  Ports       : CLK_cpu, RST                       - clock, sync reset
//                pc_valid/pc/pc_ready               - fetch request
//                icache_read_en/icache_read_addr    - cache lookup
//                icache_miss/icache_instr           - lookup result
//                icache_fetch/write_addr/write_data - cache line fill
//                mem_req/mem_addr/mem_ack/mem_rdata - memory read
//                instr_valid/instr/instr_addr       - downstream delivery
//                bus_err                            - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill #(
  parameter int ADDR_W         = icache_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = icache_pkg::TIMEOUT_CYCLES
) (
  input  logic              CLK_cpu,
  input  logic              RST,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ready,
  output logic              icache_read_en,
  output logic [ADDR_W-1:0] icache_read_addr,
  input  logic              icache_miss,
  input  logic [31:0]       icache_instr,
  output logic              icache_fetch,
  output logic [ADDR_W-1:0] icache_write_addr,
  output logic [31:0]       icache_write_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              bus_err
);

  import icache_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Every output is a register loaded from the next-state decode.
  logic              pc_ready_q,    pc_ready_d;
  logic              read_en_q,     read_en_d;
  logic [ADDR_W-1:0] read_addr_q,   read_addr_d;
  logic              fetch_q,       fetch_d;
  logic [ADDR_W-1:0] write_addr_q,  write_addr_d;
  logic [31:0]       write_data_q,  write_data_d;
  logic              mem_req_q,     mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q,       instr_d;
  logic [ADDR_W-1:0] instr_addr_q,  instr_addr_d;
  logic              bus_err_q,     bus_err_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;
  logic w_unused_pc_lsbs;

  // Fetches are word aligned; the byte offset is dropped on purpose.
  assign w_unused_pc_lsbs = ^pc[1:0];

  // Cleared while the lookup result is pending so a fresh count starts with
  // the first REFILL cycle; a cycle that carries the ack is not counted.
  assign tmr_clear = (state_q == S_LOOKUP);
  assign tmr_en    = (state_q == S_REFILL) && !mem_ack;

  refill_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_refill_timer (
    .clk_i     (CLK_cpu),
    .rst_i     (RST),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    instr_addr_d  = instr_addr_q;

    unique case (state_q)
      S_IDLE: begin
        // pc_ready_q is low in the first cycle out of reset, so nothing is
        // accepted before the handshake is actually advertised.
        if (pc_valid && pc_ready_q) begin
          addr_d  = {pc[ADDR_W-1:2], 2'b00};
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (icache_miss) begin
          state_d = S_REFILL;
        end else begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b1;
          instr_d       = icache_instr;
          instr_addr_d  = addr_q;
        end
      end
      S_REFILL: begin
        // The ack is tested first so it wins on the final allowed cycle.
        if (mem_ack) begin
          state_d       = S_FILL;
          instr_valid_d = 1'b1;
          instr_d       = mem_rdata;
          instr_addr_d  = addr_q;
        end else if (tmr_expired) begin
          state_d = S_ERROR;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pc_ready_d   = (state_d == S_IDLE);
    read_en_d    = (state_d == S_RD);
    read_addr_d  = (state_d == S_RD)     ? addr_d    : read_addr_q;
    mem_req_d    = (state_d == S_REFILL);
    mem_addr_d   = (state_d == S_REFILL) ? addr_q    : mem_addr_q;
    fetch_d      = (state_d == S_FILL);
    write_addr_d = (state_d == S_FILL)   ? addr_q    : write_addr_q;
    write_data_d = (state_d == S_FILL)   ? mem_rdata : write_data_q;
    bus_err_d    = bus_err_q | (state_d == S_ERROR);
  end

  always_ff @(posedge CLK_cpu) begin
    if (RST) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      pc_ready_q    <= 1'b0;
      read_en_q     <= 1'b0;
      read_addr_q   <= '0;
      fetch_q       <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pc_ready_q    <= pc_ready_d;
      read_en_q     <= read_en_d;
      read_addr_q   <= read_addr_d;
      fetch_q       <= fetch_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign pc_ready          = pc_ready_q;
  assign icache_read_en    = read_en_q;
  assign icache_read_addr  = read_addr_q;
  assign icache_fetch      = fetch_q;
  assign icache_write_addr = write_addr_q;
  assign icache_write_data = write_data_q;
  assign mem_req           = mem_req_q;
  assign mem_addr          = mem_addr_q;
  assign instr_valid       = instr_valid_q;
  assign instr             = instr_q;
  assign instr_addr        = instr_addr_q;
  assign bus_err           = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill
//  Description : Directed bench for icache_refill. Each scenario task drives
//                the inputs and, from the transaction it is running, queues
//                the outputs expected after every clock edge; a single
//                compare process checks them on the falling edge. Observed
//                event counts are pinned against hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill;

  localparam int AW = 20;
  localparam int TO = 255;

  logic          CLK_cpu = 1'b0;
  logic          RST;
  logic          pc_valid;
  logic [AW-1:0] pc;
  logic          pc_ready;
  logic          icache_read_en;
  logic [AW-1:0] icache_read_addr;
  logic          icache_miss;
  logic [31:0]   icache_instr;
  logic          icache_fetch;
  logic [AW-1:0] icache_write_addr;
  logic [31:0]   icache_write_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_addr;
  logic          bus_err;

  icache_refill #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_cpu(CLK_cpu), .RST(RST),
    .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .icache_read_en(icache_read_en), .icache_read_addr(icache_read_addr),
    .icache_miss(icache_miss), .icache_instr(icache_instr),
    .icache_fetch(icache_fetch), .icache_write_addr(icache_write_addr),
    .icache_write_data(icache_write_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr),
    .bus_err(bus_err)
  );

  always #5 CLK_cpu = ~CLK_cpu;

  typedef struct {
    logic          pc_ready, read_en, fetch, mem_req, ivalid, bus_err;
    logic [AW-1:0] read_addr, mem_addr, waddr, iaddr;
    logic [31:0]   wdata, instr;
  } frame_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  frame_t exp_q[$];
  lit_t   lit_q[$];
  frame_t cur;
  lit_t   lit;

  int total = 0;
  int bad   = 0;

  // Model of the output values that persist between transactions.
  logic [31:0]   m_instr = '0;
  logic [AW-1:0] m_iaddr = '0;
  logic          m_err   = 1'b0;

  // Observed events, written only by the compare process.
  int            n_memreq = 0;
  int            n_fetch  = 0;
  int            n_ivalid = 0;
  logic [31:0]   last_instr = '0;
  logic [AW-1:0] last_iaddr = '0;
  logic [AW-1:0] last_raddr = '0;

  // Snapshots taken by the stimulus process.
  int s_memreq, s_fetch, s_ivalid;

  function automatic frame_t base_f();
    frame_t f;
    f.pc_ready = 1'b0; f.read_en = 1'b0; f.fetch = 1'b0;
    f.mem_req  = 1'b0; f.ivalid  = 1'b0; f.bus_err = m_err;
    f.read_addr = '0; f.mem_addr = '0; f.waddr = '0; f.wdata = '0;
    f.instr = m_instr; f.iaddr = m_iaddr;
    return f;
  endfunction

  function automatic frame_t idle_f();
    frame_t f = base_f();
    f.pc_ready = 1'b1;
    return f;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] p);
    int v = int'(p);
    return AW'((v / 4) * 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge CLK_cpu) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("pc_ready",    32'(pc_ready),       32'(cur.pc_ready));
      chk("read_en",     32'(icache_read_en), 32'(cur.read_en));
      chk("fetch",       32'(icache_fetch),   32'(cur.fetch));
      chk("mem_req",     32'(mem_req),        32'(cur.mem_req));
      chk("instr_valid", 32'(instr_valid),    32'(cur.ivalid));
      chk("bus_err",     32'(bus_err),        32'(cur.bus_err));
      chk("instr",       instr,               cur.instr);
      chk("instr_addr",  32'(instr_addr),     32'(cur.iaddr));
      if (cur.read_en) chk("read_addr", 32'(icache_read_addr), 32'(cur.read_addr));
      if (cur.mem_req) chk("mem_addr",  32'(mem_addr),         32'(cur.mem_addr));
      if (cur.fetch) begin
        chk("write_addr", 32'(icache_write_addr), 32'(cur.waddr));
        chk("write_data", icache_write_data,      cur.wdata);
      end
      chk("no_overlap", 32'(icache_read_en & icache_fetch), 32'd0);
    end
    if (mem_req === 1'b1)        n_memreq++;
    if (icache_fetch === 1'b1)   n_fetch++;
    if (icache_read_en === 1'b1) last_raddr = icache_read_addr;
    if (instr_valid === 1'b1) begin
      n_ivalid++;
      last_instr = instr;
      last_iaddr = instr_addr;
    end
    while (lit_q.size() > 0) begin
      lit = lit_q.pop_front();
      chk(lit.nm, lit.act, lit.exp);
    end
  end

  task automatic step(input frame_t f);
    exp_q.push_back(f);
    @(posedge CLK_cpu);
    #2;
  endtask

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
    lit_t l;
    l.nm = nm; l.act = a; l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic snap();
    s_memreq = n_memreq; s_fetch = n_fetch; s_ivalid = n_ivalid;
  endtask

  task automatic do_reset();
    frame_t f;
    RST = 1'b1; pc_valid = 1'b0; mem_ack = 1'b0; icache_miss = 1'b0;
    m_instr = '0; m_iaddr = '0; m_err = 1'b0;
    f = base_f();
    step(f);
    step(f);
    RST = 1'b0;
    step(idle_f());
  endtask

  task automatic run_hit(input logic [AW-1:0] p, input logic [31:0] d, input logic keep_valid);
    logic [AW-1:0] a = align(p);
    frame_t f;
    pc_valid = 1'b1; pc = p;
    f = base_f(); f.read_en = 1'b1; f.read_addr = a;
    step(f);
    pc_valid = keep_valid; pc = p ^ 20'h00F00;
    icache_miss = 1'b1; icache_instr = 32'hBAD0BAD0;
    step(base_f());
    icache_miss = 1'b0; icache_instr = d;
    m_instr = d; m_iaddr = a;
    f = idle_f(); f.ivalid = 1'b1;
    step(f);
    pc_valid = 1'b0; icache_instr = 32'h0;
    step(idle_f());
  endtask

  // ack_at: REFILL cycle (1-based) carrying mem_ack, 0 for never.
  task automatic run_miss(input logic [AW-1:0] p, input int ack_at, input logic [31:0] d);
    logic [AW-1:0] a = align(p);
    frame_t f, rf;
    pc_valid = 1'b1; pc = p;
    f = base_f(); f.read_en = 1'b1; f.read_addr = a;
    step(f);
    pc_valid = 1'b0; pc = 20'h0; icache_miss = 1'b0; icache_instr = 32'h11111111;
    step(base_f());
    icache_miss = 1'b1;
    rf = base_f(); rf.mem_req = 1'b1; rf.mem_addr = a;
    step(rf);
    icache_miss = 1'b0;
    for (int n = 1; n <= TO; n++) begin
      mem_ack   = (n == ack_at);
      mem_rdata = (n == ack_at) ? d : (32'h0BAD0000 + 32'(n));
      if (n == ack_at) begin
        m_instr = d; m_iaddr = a;
        f = base_f(); f.fetch = 1'b1; f.waddr = a; f.wdata = d; f.ivalid = 1'b1;
        step(f);
        break;
      end else if (n == TO) begin
        m_err = 1'b1;
        step(base_f());
      end else begin
        step(rf);
      end
    end
    mem_ack = 1'b0;
    if (ack_at >= 1 && ack_at <= TO) step(idle_f());
  endtask

  task automatic run_reset_mid(input logic [AW-1:0] p);
    logic [AW-1:0] a = align(p);
    frame_t f, rf;
    pc_valid = 1'b1; pc = p;
    f = base_f(); f.read_en = 1'b1; f.read_addr = a;
    step(f);
    pc_valid = 1'b0;
    step(base_f());
    icache_miss = 1'b1;
    rf = base_f(); rf.mem_req = 1'b1; rf.mem_addr = a;
    step(rf);
    icache_miss = 1'b0; mem_ack = 1'b0;
    step(rf);
    step(rf);
    RST = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    m_instr = '0; m_iaddr = '0; m_err = 1'b0;
    step(base_f());
    RST = 1'b0; mem_ack = 1'b0;
    step(idle_f());
    step(idle_f());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; pc_valid = 1'b0; pc = '0; icache_miss = 1'b0; icache_instr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    do_reset();

    // Hit, with a stray mem_ack while no memory request is open.
    snap();
    mem_ack = 1'b1;
    run_hit(20'h00104, 32'h00A00093, 1'b0);
    mem_ack = 1'b0;
    pin("hit_instr",    last_instr,          32'h00A00093);
    pin("hit_addr",     32'(last_iaddr),     32'h00104);
    pin("hit_no_memreq", 32'(n_memreq - s_memreq), 32'd0);
    pin("hit_one_valid", 32'(n_ivalid - s_ivalid), 32'd1);

    // Misaligned pc, with pc_valid held high while busy.
    run_hit(20'h00107, 32'h12345678, 1'b1);
    pin("mis_read_addr", 32'(last_raddr), 32'h00104);
    pin("mis_instr_addr", 32'(last_iaddr), 32'h00104);

    // Miss acknowledged on REFILL cycle 5.
    snap();
    run_miss(20'h0FF08, 5, 32'hDEADBEEF);
    pin("miss_fetch_pulses", 32'(n_fetch - s_fetch),   32'd1);
    pin("miss_valid_pulses", 32'(n_ivalid - s_ivalid), 32'd1);
    pin("miss_memreq_cycles", 32'(n_memreq - s_memreq), 32'd5);
    pin("miss_instr", last_instr, 32'hDEADBEEF);

    // Ack exactly on the last allowed REFILL cycle.
    snap();
    run_miss(20'h00200, TO, 32'hCAFEF00D);
    pin("limit_memreq_cycles", 32'(n_memreq - s_memreq), 32'd255);
    pin("limit_no_err", 32'(bus_err), 32'd0);
    pin("limit_fetch_pulses", 32'(n_fetch - s_fetch), 32'd1);

    // Reset on REFILL cycle 3.
    snap();
    run_reset_mid(20'h00300);
    pin("rst_no_valid", 32'(n_ivalid - s_ivalid), 32'd0);
    pin("rst_no_fetch", 32'(n_fetch - s_fetch),   32'd0);

    // Timeout, then a late ack and new requests must have no effect.
    snap();
    run_miss(20'h00400, 0, 32'h0);
    mem_ack = 1'b1; pc_valid = 1'b1; pc = 20'h00010;
    for (int i = 0; i < 4; i++) step(base_f());
    mem_ack = 1'b0; pc_valid = 1'b0;
    pin("timeout_memreq_cycles", 32'(n_memreq - s_memreq), 32'd255);
    pin("timeout_err", 32'(bus_err), 32'd1);

    // Reset clears the error; a following hit works normally.
    do_reset();
    run_hit(20'h00010, 32'h00000013, 1'b0);

    @(negedge CLK_cpu);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
